// File: rtl/alu_result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_result_serializer                                                      |
// | Captures one ALU result and streams it to the UART TX as a byte frame:     |
// | status byte, then result bytes LSB first. Optional macro                   |
// | ALU_SER_CHECKSUM_EN appends an XOR checksum byte.                          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module alu_result_serializer #(
  parameter int DATA_WIDTH = 17
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_ovf,
  input  logic                  i_zero,
  input  logic                  i_tx_busy,
  output logic                  o_transmit,
  output logic [7:0]            o_data_tx,
  output logic                  o_ready,
  output logic                  o_overrun
);

  localparam int NUM_BYTES = (DATA_WIDTH + 7) / 8;
`ifdef ALU_SER_CHECKSUM_EN
  localparam int c_FRAME_BYTES = NUM_BYTES + 2;
`else
  localparam int c_FRAME_BYTES = NUM_BYTES + 1;
`endif
  localparam int c_IDX_W = (c_FRAME_BYTES > 2) ? $clog2(c_FRAME_BYTES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_IDX_W-1:0]      r_idx;
  logic [c_IDX_W-1:0]      w_idx_nxt;
  logic [DATA_WIDTH-1:0]   r_q;
  logic                    r_ovf;
  logic                    r_zero;
  logic                    r_transmit;
  logic [7:0]              r_data_tx;
  logic                    r_overrun;
  logic                    w_capture;
  logic                    w_issue;
  logic [NUM_BYTES*8-1:0]  w_q_pad;
  logic [7:0]              w_frame_byte;
`ifdef ALU_SER_CHECKSUM_EN
  logic [7:0]              r_csum;
`endif

  // Index 0 is the status byte; index k>0 selects result byte k-1.
  always_comb begin
    w_q_pad                  = '0;
    w_q_pad[DATA_WIDTH-1:0]  = r_q;
    w_frame_byte             = {4'hA, 2'b00, r_ovf, r_zero};
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (r_idx == c_IDX_W'(k + 1)) w_frame_byte = w_q_pad[k*8 +: 8];
    end
`ifdef ALU_SER_CHECKSUM_EN
    if (r_idx == c_LAST_IDX) w_frame_byte = r_csum;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_capture   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (!i_tx_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (i_tx_busy) w_state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!i_tx_busy) begin
          if (r_idx == c_LAST_IDX) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + c_IDX_W'(1);
            w_state_nxt = S_SEND;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_q        <= '0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
      r_transmit <= 1'b0;
      r_data_tx  <= 8'h00;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_transmit <= w_issue;
      // Acceptance looks only at the registered state, so a strobe on the
      // edge that leaves WAIT_LO is still reported as dropped.
      r_overrun  <= i_valid && (r_state != S_IDLE);
      if (w_capture) begin
        r_q    <= i_q;
        r_ovf  <= i_ovf;
        r_zero <= i_zero;
      end
      if (w_issue) r_data_tx <= w_frame_byte;
    end
  end

`ifdef ALU_SER_CHECKSUM_EN
  // Running XOR of issued bytes; ready in time for the trailing byte.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_csum <= 8'h00;
    end else if (w_capture) begin
      r_csum <= 8'h00;
    end else if (w_issue) begin
      r_csum <= r_csum ^ w_frame_byte;
    end
  end
`endif

  assign o_transmit = r_transmit;
  assign o_data_tx  = r_data_tx;
  assign o_ready    = (r_state == S_IDLE);
  assign o_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_result_serializer                                                   |
// | Directed bench with a UART-TX busy model; checks frame bytes and timing.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_alu_result_serializer;

`ifdef ALU_SER_CHECKSUM_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif
  localparam int BUSY_CYCLES = 10;

  logic        clk;
  logic        i_nrst;
  logic        i_valid;
  logic [16:0] i_q;
  logic        i_ovf;
  logic        i_zero;
  logic        i_tx_busy;
  logic        o_transmit;
  logic [7:0]  o_data_tx;
  logic        o_ready;
  logic        o_overrun;

  int          n_total;
  int          n_pass;
  int          pulses;
  int          busy_cnt;
  bit          model_en;
  bit          prev_tx;
  logic [7:0]  captured[$];

  alu_result_serializer #(.DATA_WIDTH(17)) dut (
    .i_clk      (clk),
    .i_nrst     (i_nrst),
    .i_valid    (i_valid),
    .i_q        (i_q),
    .i_ovf      (i_ovf),
    .i_zero     (i_zero),
    .i_tx_busy  (i_tx_busy),
    .o_transmit (o_transmit),
    .o_data_tx  (o_data_tx),
    .o_ready    (o_ready),
    .o_overrun  (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // UART transmitter model: busy for BUSY_CYCLES after each accepted request.
  initial begin
    forever begin
      @(negedge clk);
      if (o_transmit) begin
        pulses++;
        chk("tx_gap", {31'd0, prev_tx}, 32'd0);
      end
      prev_tx = o_transmit;
      if (model_en) begin
        if (busy_cnt != 0) begin
          busy_cnt--;
          i_tx_busy = (busy_cnt != 0);
        end else if (o_transmit) begin
          captured.push_back(o_data_tx);
          busy_cnt  = BUSY_CYCLES;
          i_tx_busy = 1'b1;
        end
      end
    end
  end

  task automatic strobe(input logic [16:0] q, input logic ovf, input logic zero);
    i_q     = q;
    i_ovf   = ovf;
    i_zero  = zero;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (o_ready && captured.size() >= FRAME && !i_tx_busy) done = 1'b1;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] exp_b[5];
    exp_b = '{e0, e1, e2, e3, e4};
    chk({tag, "_count"}, captured.size(), FRAME);
    chk({tag, "_pulses"}, pulses, FRAME);
    for (int i = 0; i < FRAME; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), (i < captured.size()) ? {24'd0, captured[i]} : 32'hFFFF, {24'd0, exp_b[i]});
    end
  endtask

  task automatic start_clean();
    captured.delete();
    pulses = 0;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    pulses    = 0;
    busy_cnt  = 0;
    model_en  = 1'b0;
    prev_tx   = 1'b0;
    i_valid   = 1'b0;
    i_q       = '0;
    i_ovf     = 1'b0;
    i_zero    = 1'b0;
    i_tx_busy = 1'b0;
    i_nrst    = 1'b1;
    #2 i_nrst = 1'b0;
    #1;
    chk("rst_transmit", {31'd0, o_transmit}, 32'd0);
    chk("rst_data", {24'd0, o_data_tx}, 32'h00);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
    repeat (2) @(negedge clk);
    i_nrst   = 1'b1;
    model_en = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame with first-byte latency
    start_clean();
    strobe(17'h1_2345, 1'b0, 1'b0);
    chk("lat_ready_low", {31'd0, o_ready}, 32'd0);
    chk("lat_tx_early", {31'd0, o_transmit}, 32'd0);
    @(negedge clk);
    chk("lat_tx", {31'd0, o_transmit}, 32'd1);
    chk("lat_data", {24'd0, o_data_tx}, 32'hA0);
    wait_done("basic_done");
    check_frame("basic", 8'hA0, 8'h45, 8'h23, 8'h01, 8'hC7);
    chk("basic_ready", {31'd0, o_ready}, 32'd1);
    repeat (3) @(negedge clk);

    // Flags with zero result
    start_clean();
    strobe(17'h0_0000, 1'b1, 1'b1);
    wait_done("flags_done");
    check_frame("flags", 8'hA3, 8'h00, 8'h00, 8'h00, 8'hA3);
    repeat (3) @(negedge clk);

    // Overrun: second strobe mid-frame is dropped
    start_clean();
    strobe(17'h1_2345, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    strobe(17'h0_00FF, 1'b1, 1'b1);
    chk("ovr_pulse", {31'd0, o_overrun}, 32'd1);
    @(negedge clk);
    chk("ovr_clear", {31'd0, o_overrun}, 32'd0);
    wait_done("ovr_done");
    check_frame("ovr", 8'hA0, 8'h45, 8'h23, 8'h01, 8'hC7);
    repeat (3) @(negedge clk);

    // Backpressure: busy held when the frame is captured
    model_en  = 1'b0;
    i_tx_busy = 1'b1;
    start_clean();
    strobe(17'h1_2345, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {31'd0, o_transmit}, 32'd0);
      @(negedge clk);
    end
    i_tx_busy = 1'b0;
    @(negedge clk);
    chk("bp_tx", {31'd0, o_transmit}, 32'd1);
    chk("bp_data", {24'd0, o_data_tx}, 32'hA2);
    captured.push_back(o_data_tx);
    busy_cnt  = BUSY_CYCLES;
    i_tx_busy = 1'b1;
    model_en  = 1'b1;
    wait_done("bp_done");
    check_frame("bp", 8'hA2, 8'h45, 8'h23, 8'h01, 8'hC5);
    repeat (3) @(negedge clk);

    // Reset mid-frame after the second byte
    start_clean();
    strobe(17'h1_2345, 1'b0, 1'b0);
    for (int i = 0; i < 200 && captured.size() < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    model_en  = 1'b0;
    i_nrst    = 1'b0;
    #1;
    chk("mrst_transmit", {31'd0, o_transmit}, 32'd0);
    chk("mrst_data", {24'd0, o_data_tx}, 32'h00);
    chk("mrst_ready", {31'd0, o_ready}, 32'd1);
    busy_cnt  = 0;
    i_tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    i_nrst   = 1'b1;
    @(negedge clk);
    start_clean();
    model_en = 1'b1;
    strobe(17'h0_00FF, 1'b0, 1'b0);
    wait_done("mrst_done");
    check_frame("mrst", 8'hA0, 8'hFF, 8'h00, 8'h00, 8'h5F);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
Downstream stage of the 17-bit sequential ALU bench: captures one ALU result (q, ovf, zero) on the ALU accept strobe and streams it autonomously to the UART transmitter as a fixed byte frame. It replaces the host-polled read-back path, so one ALU completion produces one complete UART frame with no further host commands. It sits between the ALU and the autobaud UART's transmit side.

Parameters:
DATA_WIDTH, 17, width of captured ALU result i_q
NUM_BYTES, (DATA_WIDTH+7)/8 (local, =3 at default), data bytes per frame; top byte zero-padded

Ports:
i_clk  in  1  system clock
i_nrst  in  1  asynchronous active-low reset
i_valid  in  1  one-cycle result strobe (ALU accept)
i_q  in  DATA_WIDTH  ALU result
i_ovf  in  1  ALU overflow flag
i_zero  in  1  ALU zero flag
i_tx_busy  in  1  UART transmitter busy
o_transmit  out  1  one-cycle UART transmit request
o_data_tx  out  8  byte to transmit, stable from o_transmit until next o_transmit
o_ready  out  1  high in IDLE; a frame can be accepted
o_overrun  out  1  one-cycle pulse when i_valid is dropped

Behaviour:
- Reset (async, i_nrst=0): state IDLE, o_transmit=0, o_data_tx=8'h00, o_ready=1, o_overrun=0, byte index=0, capture regs=0. Reset mid-frame aborts the frame; no partial continuation.
- Frame order: status byte {4'hA,2'b00,ovf,zero}, then data bytes LSB first: q[7:0], q[15:8], {7'd0,q[16]} at default width.
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE: on i_valid capture i_q/i_ovf/i_zero, index=0, go SEND; o_ready falls the cycle after capture.
- SEND: if i_tx_busy=0, register o_transmit=1 for one cycle and o_data_tx=frame[index], go WAIT_HI; if busy, hold in SEND.
- WAIT_HI: wait for i_tx_busy=1, then go WAIT_LO.
- WAIT_LO: wait for i_tx_busy=0; then index==last ? IDLE : (index+1, SEND).
- Latency: i_valid sampled at edge N -> o_transmit high in cycle N+2 when UART idle. Gap between bytes: >=1 idle cycle after busy falls.
- o_transmit is never high on two consecutive cycles and never high outside SEND->WAIT_HI transitions.
- i_valid while not IDLE: ignored, capture regs untouched, o_overrun pulses 1 cycle (registered, next cycle).
- i_valid on the same edge that WAIT_LO returns to IDLE: dropped with overrun (IDLE acceptance is based on the registered state only).
- If i_tx_busy never rises after a request, FSM stalls in WAIT_HI; only reset recovers (by design).
- Exactly 1+NUM_BYTES transmit pulses per accepted frame.

Optional Feature:
ALU_SER_CHECKSUM_EN: when defined, one extra trailing byte equal to the XOR of all preceding frame bytes (status included) is sent; frame = 2+NUM_BYTES bytes. Checksum is computed incrementally as bytes are issued; no extra latency before the final byte. When undefined, frame ends after the last data byte and no checksum logic is present.

Test Plan:
- Reset mid-frame: assert i_nrst=0 after 2nd byte -> o_transmit=0, o_data_tx=00, o_ready=1 immediately; next i_valid starts fresh frame from status byte.
- Basic frame: i_q=17'h1_2345, ovf=0, zero=0, UART model busy 10 cycles per byte -> bytes A0,45,23,01, exactly 4 o_transmit pulses, o_ready back to 1 after final busy falls.
- Flags/zero: i_q=0, zero=1, ovf=1 -> A3,00,00,00; with ALU_SER_CHECKSUM_EN trailing byte A3.
- Backpressure: i_tx_busy held 1 when frame captured -> no o_transmit until busy falls; then first byte A0/A1/... issued 1 cycle later.
- Overrun: second i_valid (i_q=17'h0_00FF) during frame of 17'h1_2345 -> o_overrun one cycle, transmitted bytes remain A0,45,23,01.
- Checksum (macro on): i_q=17'h1_2345, flags 0 -> A0,45,23,01,C7.
